// File: rtl/fpu_dram_responder.sv
// DRAM-side responder for the FPU line-burst handshake: moves 512-bit lines between
// the FPU ready/ready handshake and a single-ported req/gnt/rvalid line memory.
module fpu_dram_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int SIZE_WIDTH = 16,
   parameter int LINE_BITS  = 512,
   parameter int MEM_AWIDTH = ADDR_WIDTH - 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  request,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [SIZE_WIDTH-1:0] request_size,
   input  logic                  rd_wr,
   input  logic                  fpu_ready,
   input  logic [LINE_BITS-1:0]  write_data,
   output logic                  dram_ready,
   output logic [LINE_BITS-1:0]  read_data,
   output logic                  request_done,
   output logic                  busy,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_AWIDTH-1:0] mem_addr,
   output logic [LINE_BITS-1:0]  mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [LINE_BITS-1:0]  mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      WR_MEM,
      RD_REQ,
      RD_WAIT,
      RD_PRESENT,
      DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [SIZE_WIDTH-1:0] r_cnt;
   logic [SIZE_WIDTH-1:0] r_size;
   logic [SIZE_WIDTH-1:0] w_cnt_inc;
   logic                  w_last;
   logic [MEM_AWIDTH-1:0] r_mem_addr;
   logic [LINE_BITS-1:0]  r_mem_wdata;
   logic [LINE_BITS-1:0]  r_read_data;
   logic                  w_unused_addr_lsbs;

   // Byte offset within a 64-byte line carries no meaning on a line-granular port.
   assign w_unused_addr_lsbs = ^address[5:0];

   assign w_cnt_inc = r_cnt + SIZE_WIDTH'(1);
   assign w_last    = (w_cnt_inc == r_size);

   assign busy      = (r_state != IDLE);
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign read_data = r_read_data;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      dram_ready   = 1'b0;
      request_done = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      case (r_state)
         IDLE: begin
            if (request) begin
               if (request_size == '0) begin
                  w_state_next = DONE;
               end else if (rd_wr) begin
                  w_state_next = WR_WAIT;
               end else begin
                  w_state_next = RD_REQ;
               end
            end
         end
         WR_WAIT: begin
            dram_ready = 1'b1;
            if (fpu_ready) begin
               w_state_next = WR_MEM;
            end
         end
         WR_MEM: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_gnt) begin
               w_state_next = w_last ? DONE : WR_WAIT;
            end
         end
         RD_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) begin
               w_state_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (mem_rvalid) begin
               w_state_next = RD_PRESENT;
            end
         end
         RD_PRESENT: begin
            dram_ready = 1'b1;
            if (fpu_ready) begin
               w_state_next = w_last ? DONE : RD_REQ;
            end
         end
         DONE: begin
            request_done = 1'b1;
            if (fpu_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // r_mem_addr always tracks base + cnt, so wrap-around falls out of the adder width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_size      <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_read_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (request) begin
                  r_size     <= request_size;
                  r_cnt      <= '0;
                  r_mem_addr <= address[ADDR_WIDTH-1:6];
               end
            end
            WR_WAIT: begin
               if (fpu_ready) begin
                  r_mem_wdata <= write_data;
               end
            end
            WR_MEM: begin
               if (mem_gnt) begin
                  r_cnt      <= w_cnt_inc;
                  r_mem_addr <= r_mem_addr + MEM_AWIDTH'(1);
               end
            end
            RD_WAIT: begin
               if (mem_rvalid) begin
                  r_read_data <= mem_rdata;
               end
            end
            RD_PRESENT: begin
               if (fpu_ready) begin
                  r_cnt      <= w_cnt_inc;
                  r_mem_addr <= r_mem_addr + MEM_AWIDTH'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_dram_responder.sv
// Self-checking bench: random FPU/memory agents plus a transaction-level model of
// burst addressing, data ordering, handshake latencies and completion.
module tb_fpu_dram_responder;

   localparam int AW  = 32;
   localparam int SW  = 16;
   localparam int LB  = 512;
   localparam int MAW = 26;

   logic           clk;
   logic           rst;
   logic           request;
   logic [AW-1:0]  address;
   logic [SW-1:0]  request_size;
   logic           rd_wr;
   logic           fpu_ready;
   logic [LB-1:0]  write_data;
   logic           dram_ready;
   logic [LB-1:0]  read_data;
   logic           request_done;
   logic           busy;
   logic           mem_req;
   logic           mem_we;
   logic [MAW-1:0] mem_addr;
   logic [LB-1:0]  mem_wdata;
   logic           mem_gnt;
   logic           mem_rvalid;
   logic [LB-1:0]  mem_rdata;

   fpu_dram_responder dut (
      .clk          (clk),
      .rst          (rst),
      .request      (request),
      .address      (address),
      .request_size (request_size),
      .rd_wr        (rd_wr),
      .fpu_ready    (fpu_ready),
      .write_data   (write_data),
      .dram_ready   (dram_ready),
      .read_data    (read_data),
      .request_done (request_done),
      .busy         (busy),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Agent knobs, written only by the main sequence
   int             gnt_pct   = 100;
   int             fpu_pct   = 100;
   int             lat_fixed = 1;
   bit             spur_en   = 0;
   logic [MAW-1:0] hold_addr = '1;
   int             hold_len  = 0;

   logic [LB-1:0] mem_model [logic [MAW-1:0]];

   // Scoreboard state, owned by the monitor
   logic [MAW-1:0] b_base;
   int unsigned    b_size, k_fpu, k_mem, mreq_cycles;
   bit             b_wr;
   bit             exp_busy, exp_done;
   bit             want_mreq, want_dready, want_rdata_v;
   logic [LB-1:0]  want_rdata;
   bit             p_mstall, p_mwe, p_fstall;
   logic [MAW-1:0] p_maddr;
   logic [LB-1:0]  p_mwdata, p_rdata;
   logic [LB-1:0]  wq [$];
   logic [LB-1:0]  rd_log [$];
   logic [MAW-1:0] addr_log [$];

   // Memory agent state
   int            pend_cnt;
   logic [LB-1:0] pend_data;
   int            held;
   bit            rv_real;

   task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [LB-1:0] mem_rd(input logic [MAW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {16{32'(a) ^ 32'h5A5A_0000}};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
      $fatal(1);
   end

   // FPU agent: random ready, fresh write data every cycle
   initial begin
      fpu_ready  = 1'b0;
      write_data = '0;
      forever begin
         @(posedge clk);
         #1;
         fpu_ready  = ($urandom_range(99) < fpu_pct);
         write_data = rand_line();
      end
   end

   // Memory agent: random grants, fixed or random read latency, spurious rvalid noise
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      pend_cnt = 0; held = 0; rv_real = 0; pend_data = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; rv_real = 0;
         mem_rdata = rand_line();
         if (rst) begin
            pend_cnt = 0;
            held = 0;
         end else begin
            if (!busy) held = 0;
            if (pend_cnt > 0) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  mem_rvalid = 1'b1;
                  rv_real    = 1;
                  mem_rdata  = pend_data;
               end
            end else if (spur_en && !mem_req && $urandom_range(4) == 0) begin
               mem_rvalid = 1'b1;
            end
            if (mem_req) begin
               if (hold_len > 0 && mem_addr == hold_addr && held < hold_len) held++;
               else mem_gnt = ($urandom_range(99) < gnt_pct);
            end
            if (mem_req && mem_gnt) begin
               if (mem_we) begin
                  mem_model[mem_addr] = mem_wdata;
               end else begin
                  pend_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                  pend_data = mem_rd(mem_addr);
               end
            end
         end
      end
   end

   // Compare process: checks this cycle's outputs, then predicts what the coming edge implies
   always @(negedge clk) begin : monitor
      bit nx_busy, nx_done;
      logic [MAW-1:0] ea;
      if (rst) begin
         check("rst_busy", busy, 0);
         check("rst_dram_ready", dram_ready, 0);
         check("rst_request_done", request_done, 0);
         check("rst_mem_req", mem_req, 0);
         exp_busy = 0; exp_done = 0;
         want_mreq = 0; want_dready = 0; want_rdata_v = 0;
         p_mstall = 0; p_fstall = 0;
      end else begin
         check("busy", busy, exp_busy);
         check("request_done", request_done, exp_done);
         if (!exp_busy || exp_done) begin
            check("quiet_dram_ready", dram_ready, 0);
            check("quiet_mem_req", mem_req, 0);
         end
         check("ready_and_req_exclusive", dram_ready & mem_req, 0);
         if (want_mreq) begin
            check("lat_mem_req", mem_req, 1);
            check("lat_mem_we", mem_we, b_wr);
         end
         if (want_dready) begin
            check("lat_dram_ready", dram_ready, 1);
            if (want_rdata_v) check("read_data_latched", read_data, want_rdata);
         end
         if (p_mstall) begin
            check("stall_mem_req", mem_req, 1);
            check("stall_mem_we", mem_we, p_mwe);
            check("stall_mem_addr", mem_addr, p_maddr);
            if (p_mwe) check("stall_mem_wdata", mem_wdata, p_mwdata);
         end
         if (p_fstall) begin
            check("stall_dram_ready", dram_ready, 1);
            if (!b_wr) check("stall_read_data", read_data, p_rdata);
         end

         nx_busy = exp_busy; nx_done = exp_done;
         want_mreq = 0; want_dready = 0; want_rdata_v = 0;
         if (!exp_busy) begin
            if (request) begin
               b_base = address[AW-1:6];
               b_size = request_size;
               b_wr   = rd_wr;
               k_fpu = 0; k_mem = 0; mreq_cycles = 0;
               wq.delete(); rd_log.delete(); addr_log.delete();
               nx_busy = 1;
               if (request_size == 0) nx_done = 1;
               else if (rd_wr) want_dready = 1;
               else want_mreq = 1;
            end
         end else if (!exp_done) begin
            if (mem_req) mreq_cycles++;
            if (mem_req && mem_gnt) begin
               ea = b_base + MAW'(k_mem);
               check("mem_we", mem_we, b_wr);
               check("mem_addr", mem_addr, ea);
               addr_log.push_back(mem_addr);
               if (b_wr) begin
                  check("write_beat_before_access", (wq.size() > k_mem), 1);
                  if (wq.size() > k_mem) check("mem_wdata", mem_wdata, wq[k_mem]);
               end
               k_mem++;
               if (b_wr) begin
                  if (k_mem == b_size) nx_done = 1;
                  else want_dready = 1;
               end
            end
            if (dram_ready && fpu_ready) begin
               if (b_wr) begin
                  wq.push_back(write_data);
                  want_mreq = 1;
               end else begin
                  ea = b_base + MAW'(k_fpu);
                  check("read_beat_data", read_data, mem_rd(ea));
                  rd_log.push_back(read_data);
               end
               k_fpu++;
               if (!b_wr) begin
                  if (k_fpu == b_size) nx_done = 1;
                  else want_mreq = 1;
               end
            end
            if (mem_rvalid && rv_real) begin
               want_dready  = 1;
               want_rdata   = mem_rdata;
               want_rdata_v = 1;
            end
         end else if (fpu_ready) begin
            check("beat_count", k_fpu, b_size);
            check("access_count", k_mem, b_size);
            nx_done = 0;
            nx_busy = 0;
         end
         exp_busy = nx_busy;
         exp_done = nx_done;
         p_mstall = mem_req && !mem_gnt;
         p_mwe    = mem_we;
         p_maddr  = mem_addr;
         p_mwdata = mem_wdata;
         p_fstall = dram_ready && !fpu_ready;
         p_rdata  = read_data;
      end
   end

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      request = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   task automatic start_burst(input logic [AW-1:0] addr, input int unsigned size, input bit wr);
      @(posedge clk);
      #1;
      address      = addr;
      request_size = SW'(size);
      rd_wr        = wr;
      request      = 1'b1;
      @(posedge clk);
      #1;
      request = 1'b0;
   endtask

   // Runs one burst to completion, with request noise while busy that must be ignored
   task automatic run_burst(input logic [AW-1:0] addr, input int unsigned size, input bit wr,
                            input int max_cyc);
      int n;
      start_burst(addr, size, wr);
      n = 0;
      while (busy && n < max_cyc) begin
         request      = ($urandom_range(3) == 0);
         address      = $urandom;
         request_size = SW'($urandom);
         rd_wr        = 1'($urandom_range(1));
         @(posedge clk);
         #1;
         n++;
      end
      request = 1'b0;
      check("burst_finished_in_time", (n < max_cyc), 1);
      if (n >= max_cyc) pulse_reset();
   endtask

   initial begin
      logic [LB-1:0] line;
      int n;
      rst = 1'b1; request = 1'b0; address = '0; request_size = '0; rd_wr = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", busy, 0);
      check("reset_dram_ready", dram_ready, 0);
      check("reset_request_done", request_done, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_mem_we", mem_we, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_read_data", read_data, 0);
      check("reset_mem_wdata", mem_wdata, 0);
      #1;
      rst = 1'b0;

      // Write burst, 4 lines at byte 0x1000, no stalls
      run_burst(32'h0000_1000, 4, 1'b1, 200);
      check("wr4_access_count", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         check("wr4_first_line_addr", addr_log[0], 26'h40);
         check("wr4_last_line_addr", addr_log[3], 26'h43);
      end

      // Read burst, 8 preloaded lines, rvalid 3 cycles after gnt, FPU stalls, rvalid noise
      for (int i = 0; i < 8; i++) mem_model[MAW'(i)] = rand_line();
      line = mem_model[MAW'(0)];
      line[511:504] = 8'hA5;
      mem_model[MAW'(0)] = line;
      lat_fixed = 3; fpu_pct = 60; spur_en = 1;
      run_burst(32'h0000_0000, 8, 1'b0, 600);
      check("rd8_lines_received", rd_log.size(), 8);
      if (rd_log.size() == 8) begin
         line = rd_log[0];
         check("rd8_byte0_msb", line[511:504], 8'hA5);
      end

      // Zero-size read: straight to done, no memory traffic
      run_burst(32'h0000_2000, 0, 1'b0, 100);
      check("size0_mem_req_cycles", mreq_cycles, 0);
      check("size0_accesses", addr_log.size(), 0);

      // Line address wrap at the top of the memory space
      gnt_pct = 70; fpu_pct = 100;
      run_burst({26'h3FF_FFFE, 6'h15}, 3, 1'b1, 300);
      check("wrap_access_count", addr_log.size(), 3);
      if (addr_log.size() == 3) begin
         check("wrap_addr0", addr_log[0], 26'h3FF_FFFE);
         check("wrap_addr1", addr_log[1], 26'h3FF_FFFF);
         check("wrap_addr2", addr_log[2], 26'h000_0000);
      end

      // Grant withheld 5 cycles on the second write line
      gnt_pct = 100; hold_addr = 26'h201; hold_len = 5;
      run_burst(32'h0000_8000, 4, 1'b1, 300);
      check("gnt_hold_mem_req_cycles", mreq_cycles, 9);
      check("gnt_hold_access_count", addr_log.size(), 4);
      hold_len = 0;

      // Asynchronous reset after 2 of 6 read lines, then a fresh write burst
      lat_fixed = 2; fpu_pct = 100;
      start_burst(32'h0000_4000, 6, 1'b0);
      n = 0;
      while (k_fpu < 2 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("mid_reset_two_lines_read", (k_fpu >= 2), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_dram_ready", dram_ready, 0);
      check("async_rst_mem_req", mem_req, 0);
      check("async_rst_mem_we", mem_we, 0);
      check("async_rst_request_done", request_done, 0);
      check("async_rst_mem_addr", mem_addr, 0);
      check("async_rst_read_data", read_data, 0);
      check("async_rst_mem_wdata", mem_wdata, 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      run_burst(32'h0004_0000, 3, 1'b1, 300);
      check("post_rst_access_count", addr_log.size(), 3);
      if (addr_log.size() == 3) check("post_rst_first_addr", addr_log[0], 26'h1000);

      // Random bursts over a small line window so reads revisit written lines
      for (int it = 0; it < 12; it++) begin
         gnt_pct   = $urandom_range(40, 100);
         fpu_pct   = $urandom_range(40, 100);
         lat_fixed = $urandom_range(0, 4);
         run_burst((32'($urandom_range(15)) << 6) | 32'($urandom_range(63)),
                   $urandom_range(0, 6), 1'($urandom_range(1)), 2000);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
